fifo_read_controller: RTL
=========================

Name: fifo_read_controller

Overview:
Read-side consumer for the asynchronous FIFO. It lives entirely in the read clock domain and drains the FIFO through its read port (r_enable/rdata/empty), converting it into a valid/ready stream for downstream logic. A 2-entry skid buffer hides the FIFO's one-cycle read latency, so throughput is one word per cycle under backpressure. A flush function discards buffered and queued FIFO contents, and a counter reports delivered words.

Parameters:
BITSIZE, 8, width of a data word; must match the FIFO BITSIZE.
COUNTWIDTH, 16, width of the delivered-word counter.

Ports:
r_clk  input  1  read-domain clock; the same clock as the FIFO r_clk.
reset_n  input  1  synchronous active-low reset, sampled on the r_clk rising edge.
fifo_empty  input  1  FIFO empty flag.
fifo_rdata  input  BITSIZE  FIFO read data; valid one cycle after an accepted read.
fifo_r_enable  output  1  FIFO read request.
m_valid  output  1  downstream data valid.
m_data  output  BITSIZE  downstream data.
m_ready  input  1  downstream ready.
flush  input  1  single-cycle request to discard all pending data.
flush_busy  output  1  high while a flush is in progress.
word_count  output  COUNTWIDTH  number of words accepted downstream; wraps modulo 2^COUNTWIDTH.

Behaviour:
- Reset (reset_n=0 at a rising edge):
  - state=IDLE; occ=0; in_flight=0.
  - m_valid=0, m_data=0, flush_busy=0, word_count=0.
  - fifo_r_enable is 0 during any cycle with reset_n=0.
  - A read in flight at reset is discarded.
- Read issue:
  - A read is issued when fifo_r_enable=1 and fifo_empty=0; fifo_r_enable is never driven high while fifo_empty=1.
  - fifo_r_enable is combinational from fifo_empty, the registered occ/in_flight, and pop.
  - In IDLE/STREAM, issue when (occ+in_flight)<2, or when (occ+in_flight)==2 and pop=1.
  - in_flight is set on the edge after an issue.
  - On the following edge, fifo_rdata is written to the buffer tail and occ increments.
- Pop:
  - pop = m_valid & m_ready.
  - The head entry is removed on that edge.
  - Simultaneous pop and fill leaves occ unchanged and preserves order.
- Outputs:
  - m_valid = (occ!=0) in IDLE/STREAM; m_data = head entry.
  - While m_valid=1 and m_ready=0, m_data is held stable.
  - Words are delivered in FIFO order with no loss or duplication.
- Latency: fifo_empty falling in cycle N gives a read in N, fifo_rdata in N+1, m_valid=1 in N+2.
- Throughput: with m_ready held high and the FIFO non-empty, one word per cycle is delivered.
- Invariant: occ+in_flight ≤ 2 at all times. A bench must flag any violation.
- FSM:
  - IDLE → STREAM when a read is issued.
  - STREAM → IDLE when occ=0, in_flight=0 and fifo_empty=1.
  - IDLE/STREAM → FLUSH when flush=1. Flush has priority over pop in the same cycle: that pop is not counted and the word is dropped.
  - FLUSH actions: flush_busy=1, m_valid=0, occ cleared, returning in-flight data discarded, fifo_r_enable = ~fifo_empty every cycle.
  - FLUSH → IDLE when fifo_empty=1 and in_flight=0. flush_busy falls on the same edge.
  - flush asserted while already in FLUSH is ignored.
- word_count:
  - Increments by 1 per pop.
  - 2^COUNTWIDTH−1 wraps to 0.
  - Not cleared by flush; only reset clears it.
- Empty boundary: if fifo_empty rises in the same cycle as a planned read, no read is issued and nothing is captured.

Test Plan:
- Single word: FIFO holds 0xA5, m_ready=1 → fifo_r_enable pulses once; m_valid=1 with m_data=0xA5 exactly 2 cycles after fifo_empty falls; word_count=1; FSM returns to IDLE.
- Streaming: 32 words 0x00..0x1F, m_ready=1 → 32 consecutive m_valid cycles, data in order, word_count=32, no bubbles after the first.
- Backpressure: 8 words, m_ready low for 5 cycles after the first valid → m_data stays at 0x00, occ+in_flight ≤ 2, fifo_r_enable=0 while the buffer is full; all 8 words are delivered in order after release.
- Flush: 20 words queued, m_ready=0, flush pulsed → m_valid=0 next cycle; flush_busy stays high until the FIFO is empty and in_flight=0; word_count is unchanged; later words are delivered normally.
- Reset mid-stream: reset_n=0 with occ=2 and in_flight=1 → next cycle m_valid=0, m_data=0, word_count=0, fifo_r_enable=0; no stale word appears after release.
- Counter wrap: COUNTWIDTH=4, 17 words → word_count reads 1.

Source files
------------

// File: rtl/fifo_read_controller.sv
// fifo_read_controller: drains the async FIFO read port into a valid/ready stream
// through a 2-entry skid buffer, with flush and a delivered-word counter.
module fifo_read_controller #(
    parameter int BITSIZE    = 8,
    parameter int COUNTWIDTH = 16
) (
    input  logic                  r_clk,
    input  logic                  reset_n,
    input  logic                  fifo_empty,
    input  logic [BITSIZE-1:0]    fifo_rdata,
    output logic                  fifo_r_enable,
    output logic                  m_valid,
    output logic [BITSIZE-1:0]    m_data,
    input  logic                  m_ready,
    input  logic                  flush,
    output logic                  flush_busy,
    output logic [COUNTWIDTH-1:0] word_count
);
    typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

    state_t                state_q, state_d;
    logic [1:0]            occ_q, occ_d, occ_p, used;
    logic                  inflight_q;
    logic [BITSIZE-1:0]    b0_q, b0_d, b1_q, b1_d;
    logic [COUNTWIDTH-1:0] cnt_q, cnt_d;
    logic                  in_flush, pop, fill;

    always_comb begin
        in_flush      = state_q == FLUSH;
        m_valid       = ~in_flush & (occ_q != 2'd0);
        m_data        = b0_q;
        flush_busy    = in_flush;
        word_count    = cnt_q;
        // a flush in the same cycle wins over the pop, so that word is dropped uncounted
        pop           = m_valid & m_ready & ~flush;
        used          = occ_q + {1'b0, inflight_q};
        fifo_r_enable = reset_n & ~fifo_empty & (in_flush | used < 2'd2 | (used == 2'd2 & pop));
        fill          = inflight_q & ~in_flush & ~flush;
        occ_p         = occ_q - {1'b0, pop};
        b0_d          = pop ? b1_q : b0_q;
        b1_d          = b1_q;
        if (fill && occ_p == 2'd0)
            b0_d = fifo_rdata;
        else if (fill)
            b1_d = fifo_rdata;
        occ_d         = (in_flush | flush) ? 2'd0 : occ_p + {1'b0, fill};
        cnt_d         = cnt_q + COUNTWIDTH'(pop);
        state_d       = (~in_flush & flush)                                                ? FLUSH  :
                        (state_q == IDLE & fifo_r_enable)                                  ? STREAM :
                        (state_q == STREAM & occ_q == 2'd0 & ~inflight_q & fifo_empty)    ? IDLE   :
                        (in_flush & ~inflight_q & fifo_empty)                              ? IDLE   : state_q;
    end

    always_ff @(posedge r_clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            b0_q       <= '0;
            b1_q       <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            occ_q      <= occ_d;
            inflight_q <= fifo_r_enable;
            b0_q       <= b0_d;
            b1_q       <= b1_d;
            cnt_q      <= cnt_d;
        end
    end
endmodule
